maquina_cafe_param: RTL
=======================

Name: maquina_cafe_param

Overview:
Parametrised coffee-machine sequencer, the successor of the fixed 9-state brew FSM.
- Keeps the same state encoding and brew order.
- Adds configurable dwell time per step and a multi-cup reservoir with level tracking.
- Adds selectable shot count, abort/discard path, and busy/done status.
- Top-level controller; state output drives display/debug logic.

Parameters:
STEP_CYCLES, 3, dwell cycles of every timed step (>=1)
FILL_CYCLES, 8, dwell cycles of ENCHER_RESERVATORIO (>=1)
CUPS_PER_FILL, 4, cups delivered by one reservoir fill (>=1)
LVL_W, $clog2(CUPS_PER_FILL+1), width of water_level (derived, do not override)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request one cup; sampled only in IDLE
abort  input  1  cancel current brew; ignored in IDLE and DESCARTAR
shots  input  2  extraction repetitions; 0 treated as 1; latched at start
state  output  4  current state code
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse after a completed brew
water_level  output  LVL_W  cups remaining in reservoir

Behaviour:
- Reset (async): state=IDLE, water_level=0, done=0, busy=0, step timer=0, shot counter=0, latched shots=1.
- State codes: IDLE 0, LIGAR_MAQUINA 1, VERIFICAR_AGUA 2, ENCHER_RESERVATORIO 3, MOER_CAFE 4, COLOCAR_NO_FILTRO 5, PASSAR_AGITADOR 6, TAMPEAR 7, REALIZAR_EXTRACAO 8, DESCARTAR 9. Codes 10-15 -> IDLE next cycle.
- IDLE:
  - start=1 at an edge -> LIGAR_MAQUINA.
  - Latch shots, with 0 latched as 1.
  - start is ignored in every other state (no queuing).
- Timed states (1,4,5,6,7,9): stay exactly STEP_CYCLES cycles. The timer clears on every state entry.
- VERIFICAR_AGUA: exactly 1 cycle.
  - water_level>=1 -> MOER_CAFE.
  - Otherwise -> ENCHER_RESERVATORIO.
- ENCHER_RESERVATORIO:
  - Stays FILL_CYCLES cycles.
  - On exit, water_level<=CUPS_PER_FILL and next state = VERIFICAR_AGUA.
- Order after MOER: 4 -> 5 -> 6 -> 7 -> 8.
- REALIZAR_EXTRACAO:
  - Stays STEP_CYCLES*shots_latched cycles; the shot counter increments every STEP_CYCLES.
  - On exit, water_level decrements by 1 (never below 0), next state = IDLE, and done=1 in the first IDLE cycle only.
- abort=1 in states 1-8 at an edge -> DESCARTAR.
  - abort has priority over timer expiry and fill completion.
  - An interrupted fill does not update water_level.
  - An aborted extraction does not decrement water_level.
- DESCARTAR: stays STEP_CYCLES cycles, then -> IDLE; no done pulse.
- Latency with water present, S=STEP_CYCLES, N=shots: 5S+1+S*N non-IDLE cycles.
  - Empty reservoir adds FILL_CYCLES+1.
- done and busy are registered or decoded from registered state; no combinational path from inputs to outputs.
- Reset mid-operation: immediate return to reset values, including water_level=0.

Decomposition:
- Package maquina_cafe_pkg: state code constants (4-bit, 0-9) and the STATE_W=4 constant.
- Sub-module step_timer:
  - Loadable down-counter with a load value and an expire flag.
  - Width $clog2(max(3*STEP_CYCLES,FILL_CYCLES)+1).
  - One instance shared by all timed states.

Test Plan (S=3, F=8, C=4 unless stated):
- Reset, then idle 5 cycles with start=0 -> state=0, busy=0, done=0, water_level=0 throughout.
- start pulse with shots=1 on an empty reservoir:
  - State sequence 1x3, 2, 3x8, 2, 4x3, 5x3, 6x3, 7x3, 8x3, then 0.
  - done=1 exactly one cycle and water_level=3 at the end; 28 busy cycles total.
- Four more brews with shots=1:
  - The first three skip state 3 (19 busy cycles each) and water_level goes 2, 1, 0.
  - The fourth refills; water_level ends at 3.
- shots=2 -> state 8 held 6 cycles.
- shots=0 -> state 8 held 3 cycles.
- start pulsed during MOER -> no effect and no second brew afterwards.
- abort in 2nd cycle of MOER_CAFE (water_level=3):
  - state 9 for 3 cycles, then 0.
  - No done pulse; water_level stays 3.
  - abort while in IDLE -> no state change.
- rst_n low mid-ENCHER_RESERVATORIO -> state=0, water_level=0 immediately (async).
- After release, the next start refills (state 3 visited).

Source files
------------

// File: rtl/maquina_cafe_pkg.sv
// Shared state codes and helpers for the parametrised coffee-machine sequencer.
// State codes are fixed and must match the display/debug decoder.
package maquina_cafe_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE                = 4'd0,
    ST_LIGAR_MAQUINA       = 4'd1,
    ST_VERIFICAR_AGUA      = 4'd2,
    ST_ENCHER_RESERVATORIO = 4'd3,
    ST_MOER_CAFE           = 4'd4,
    ST_COLOCAR_NO_FILTRO   = 4'd5,
    ST_PASSAR_AGITADOR     = 4'd6,
    ST_TAMPEAR             = 4'd7,
    ST_REALIZAR_EXTRACAO   = 4'd8,
    ST_DESCARTAR           = 4'd9
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Brewing states (1-8) are the only ones an abort can interrupt.
  function automatic logic is_abortable(input state_t s);
    logic r;
    case (s)
      ST_LIGAR_MAQUINA, ST_VERIFICAR_AGUA, ST_ENCHER_RESERVATORIO,
      ST_MOER_CAFE, ST_COLOCAR_NO_FILTRO, ST_PASSAR_AGITADOR,
      ST_TAMPEAR, ST_REALIZAR_EXTRACAO: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/maquina_cafe_step_timer.sv
// Loadable dwell down-counter shared by every timed state of the sequencer.
// expire is high while the count sits at zero, i.e. in the last cycle of a dwell.
module step_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expire
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesised flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/maquina_cafe_param.sv
// Parametrised coffee-machine sequencer: brew order, per-step dwell, reservoir
// level tracking, multi-shot extraction and an abort/discard path.
module maquina_cafe_param
  import maquina_cafe_pkg::*;
#(
  parameter int STEP_CYCLES   = 3,
  parameter int FILL_CYCLES   = 8,
  parameter int CUPS_PER_FILL = 4,
  parameter int LVL_W         = $clog2(CUPS_PER_FILL + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         shots,
  output logic [STATE_W-1:0] state,
  output logic               busy,
  output logic               done,
  output logic [LVL_W-1:0]   water_level
);

  // Longest single dwell is one extraction shot or a fill; 3*STEP keeps headroom
  // for a whole extraction should it ever be loaded in one go.
  localparam int TMR_MAX = max_int(3 * STEP_CYCLES, FILL_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] STEP_LOAD = TMR_W'(STEP_CYCLES - 1);
  localparam logic [TMR_W-1:0] FILL_LOAD = TMR_W'(FILL_CYCLES - 1);

  state_t             st;
  logic [1:0]         shots_lat;
  logic [1:0]         shot_cnt;
  logic [LVL_W-1:0]   level;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_value;
  logic               tmr_expire;
  logic               go_start;
  logic               go_abort;
  logic               last_shot;

  step_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .expire     (tmr_expire)
  );

  // The timer is reloaded on the same edge the FSM changes state, so each
  // state sees a fresh count from its first cycle. Exits to IDLE leave it at 0.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    go_start  = (st == ST_IDLE) && start;
    go_abort  = abort && is_abortable(st);
    last_shot = (shot_cnt == shots_lat - 2'd1);
    tmr_load  = 1'b0;
    tmr_value = STEP_LOAD;
    if (go_start || go_abort) begin
      tmr_load = 1'b1;
    end else begin
      case (st)
        ST_VERIFICAR_AGUA: begin
          tmr_load = 1'b1;
          if (level == '0) tmr_value = FILL_LOAD;
        end
        ST_LIGAR_MAQUINA, ST_ENCHER_RESERVATORIO, ST_MOER_CAFE,
        ST_COLOCAR_NO_FILTRO, ST_PASSAR_AGITADOR, ST_TAMPEAR:
          tmr_load = tmr_expire;
        ST_REALIZAR_EXTRACAO:
          tmr_load = tmr_expire && !last_shot;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      shots_lat <= 2'd1;
      shot_cnt  <= 2'd0;
      level     <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go_abort) begin
        st <= ST_DESCARTAR;
      end else begin
        case (st)
          ST_IDLE: begin
            if (start) begin
              st        <= ST_LIGAR_MAQUINA;
              shots_lat <= (shots == 2'd0) ? 2'd1 : shots;
              shot_cnt  <= 2'd0;
            end
          end
          ST_LIGAR_MAQUINA:
            if (tmr_expire) st <= ST_VERIFICAR_AGUA;
          ST_VERIFICAR_AGUA:
            st <= (level != '0) ? ST_MOER_CAFE : ST_ENCHER_RESERVATORIO;
          ST_ENCHER_RESERVATORIO: begin
            if (tmr_expire) begin
              level <= LVL_W'(CUPS_PER_FILL);
              st    <= ST_VERIFICAR_AGUA;
            end
          end
          ST_MOER_CAFE:
            if (tmr_expire) st <= ST_COLOCAR_NO_FILTRO;
          ST_COLOCAR_NO_FILTRO:
            if (tmr_expire) st <= ST_PASSAR_AGITADOR;
          ST_PASSAR_AGITADOR:
            if (tmr_expire) st <= ST_TAMPEAR;
          ST_TAMPEAR:
            if (tmr_expire) st <= ST_REALIZAR_EXTRACAO;
          ST_REALIZAR_EXTRACAO: begin
            if (tmr_expire) begin
              if (last_shot) begin
                st       <= ST_IDLE;
                done     <= 1'b1;
                shot_cnt <= 2'd0;
                if (level != '0) level <= level - LVL_W'(1);
              end else begin
                shot_cnt <= shot_cnt + 2'd1;
              end
            end
          end
          ST_DESCARTAR:
            if (tmr_expire) st <= ST_IDLE;
          default:
            st <= ST_IDLE;
        endcase
      end
    end
  end

  assign state       = st;
  assign busy        = (st != ST_IDLE);
  assign water_level = level;

endmodule
